traffic_light_monitor: RTL and testbench

//  Receive-side checker for the 6-bit two-road traffic light bus {R1,Y1,G1,R2,Y2,G2}.

---
 rtl/traffic_light_monitor_pkg.sv | 29 ++
 rtl/traffic_light_monitor_light_code_decode.sv | 25 ++
 rtl/traffic_light_monitor.sv | 137 +++++++++++++
 tb/tb_traffic_light_monitor.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_light_monitor_pkg.sv
// Shared constants and types for the traffic light bus monitor.
// Light codes are {R1,Y1,G1,R2,Y2,G2}; phases P0..P5, with PH_NONE while unlocked.
package traffic_light_monitor_pkg;

  localparam logic [5:0] LT_P0  = 6'b100001;
  localparam logic [5:0] LT_P1  = 6'b100010;
  localparam logic [5:0] LT_RED = 6'b100100;
  localparam logic [5:0] LT_P3  = 6'b001100;
  localparam logic [5:0] LT_P4  = 6'b010100;

  localparam logic [2:0] PH_P0   = 3'd0;
  localparam logic [2:0] PH_P1   = 3'd1;
  localparam logic [2:0] PH_P2   = 3'd2;
  localparam logic [2:0] PH_P3   = 3'd3;
  localparam logic [2:0] PH_P4   = 3'd4;
  localparam logic [2:0] PH_P5   = 3'd5;
  localparam logic [2:0] PH_NONE = 3'd7;

  localparam int DEF_GREEN_CYC = 6;
  localparam int DEF_SHORT_CYC = 2;
  localparam int DEF_CNT_W     = 4;

  typedef enum logic {ST_UNLOCKED, ST_LOCKED} mon_state_e;

  function automatic logic [2:0] next_phase(input logic [2:0] ph);
    return (ph == PH_P5) ? PH_P0 : ph + 3'd1;
  endfunction

endpackage

// File: rtl/traffic_light_monitor_light_code_decode.sv
// Combinational decode of a light code into a phase; the all-red code is
// P5 when it follows P4 and P2 otherwise.
module light_code_decode
  import traffic_light_monitor_pkg::*;
(
  input  logic [5:0] code,
  input  logic [2:0] prev_phase,
  output logic       legal,
  output logic [2:0] phase
);

  always_comb begin
    legal = 1'b1;
    phase = PH_NONE;
    case (code)
      LT_P0:   phase = PH_P0;
      LT_P1:   phase = PH_P1;
      LT_RED:  phase = (prev_phase == PH_P4) ? PH_P5 : PH_P2;
      LT_P3:   phase = PH_P3;
      LT_P4:   phase = PH_P4;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker for the two-road light bus: locks onto the phase cycle, measures
// dwell and flags code/sequence/dwell errors. Optional MON_ERR_CAPTURE_EN adds first-error capture.
module traffic_light_monitor
  import traffic_light_monitor_pkg::*;
#(
  parameter int GREEN_CYC = DEF_GREEN_CYC,
  parameter int SHORT_CYC = DEF_SHORT_CYC,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [5:0]       lights_in,
  output logic             locked,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] dwell,
  output logic             cycle_done,
  output logic [7:0]       cycle_cnt,
  output logic             err_code,
  output logic             err_seq,
  output logic             err_dwell,
  output logic             err_any
`ifdef MON_ERR_CAPTURE_EN
  ,
  output logic             cap_valid,
  output logic [5:0]       cap_code,
  output logic [2:0]       cap_phase,
  output logic [CNT_W-1:0] cap_dwell
`endif
);

  localparam logic [CNT_W-1:0] GREEN_REQ = CNT_W'(GREEN_CYC);
  localparam logic [CNT_W-1:0] SHORT_REQ = CNT_W'(SHORT_CYC);
  localparam logic [CNT_W-1:0] DWELL_MAX = '1;

  mon_state_e       state;
  logic [5:0]       lights_q;
  logic             dec_legal;
  logic [2:0]       dec_phase;
  logic             change;
  logic             succ_ok;
  logic [CNT_W-1:0] dwell_inc;
  logic [CNT_W-1:0] req;
  logic             ev_code, ev_seq, ev_short, ev_long, ev_any;

  light_code_decode u_decode (
    .code       (lights_in),
    .prev_phase (phase),
    .legal      (dec_legal),
    .phase      (dec_phase)
  );

  always_comb begin
    change    = (lights_in != lights_q);
    dwell_inc = (dwell == DWELL_MAX) ? dwell : dwell + CNT_W'(1);
    req       = (phase == PH_P0 || phase == PH_P3) ? GREEN_REQ : SHORT_REQ;
    succ_ok   = dec_legal && (dec_phase == next_phase(phase));
    ev_code   = (state == ST_LOCKED) && change && !dec_legal;
    ev_seq    = (state == ST_LOCKED) && change && dec_legal && !succ_ok;
    ev_short  = (state == ST_LOCKED) && change && dec_legal && (dwell < req);
    // Over-long dwell fires once, on the edge that carries dwell past req.
    ev_long   = (state == ST_LOCKED) && !change && (dwell == req) && (dwell != DWELL_MAX);
    ev_any    = ev_code | ev_seq | ev_short | ev_long;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state      <= ST_UNLOCKED;
      lights_q   <= LT_P0;
      locked     <= 1'b0;
      phase      <= PH_NONE;
      dwell      <= '0;
      cycle_done <= 1'b0;
      cycle_cnt  <= 8'd0;
      err_code   <= 1'b0;
      err_seq    <= 1'b0;
      err_dwell  <= 1'b0;
      err_any    <= 1'b0;
    end else begin
      lights_q   <= lights_in;
      cycle_done <= 1'b0;
      err_code   <= ev_code;
      err_seq    <= ev_seq;
      err_dwell  <= ev_short | ev_long;
      if (ev_any) err_any <= 1'b1;
      case (state)
        ST_UNLOCKED: begin
          if (change && lights_in == LT_P0) begin
            state  <= ST_LOCKED;
            locked <= 1'b1;
            phase  <= PH_P0;
            dwell  <= CNT_W'(1);
          end else begin
            dwell  <= dwell_inc;
          end
        end
        ST_LOCKED: begin
          if (!change) begin
            dwell <= dwell_inc;
          end else if (succ_ok) begin
            phase <= dec_phase;
            dwell <= CNT_W'(1);
            if (phase == PH_P5) begin
              cycle_done <= 1'b1;
              cycle_cnt  <= cycle_cnt + 8'd1;
            end
          end else if (dec_legal && lights_in == LT_P0) begin
            // Wrong successor that lands on P0 re-locks on the same edge.
            phase <= PH_P0;
            dwell <= CNT_W'(1);
          end else begin
            state  <= ST_UNLOCKED;
            locked <= 1'b0;
            phase  <= PH_NONE;
            dwell  <= CNT_W'(1);
          end
        end
      endcase
    end
  end

`ifdef MON_ERR_CAPTURE_EN
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cap_valid <= 1'b0;
      cap_code  <= 6'd0;
      cap_phase <= 3'd0;
      cap_dwell <= '0;
    end else if (ev_any && !cap_valid) begin
      cap_valid <= 1'b1;
      cap_code  <= lights_in;
      cap_phase <= phase;
      cap_dwell <= dwell;
    end
  end
`endif

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor; define MON_ERR_CAPTURE_EN to also
// check the first-error capture outputs.
module tb_traffic_light_monitor;
  import traffic_light_monitor_pkg::*;

  logic       clk = 1'b0;
  logic       clr_n;
  logic [5:0] lights_in;
  logic       locked;
  logic [2:0] phase;
  logic [3:0] dwell;
  logic       cycle_done;
  logic [7:0] cycle_cnt;
  logic       err_code, err_seq, err_dwell, err_any;
`ifdef MON_ERR_CAPTURE_EN
  logic       cap_valid;
  logic [5:0] cap_code;
  logic [2:0] cap_phase;
  logic [3:0] cap_dwell;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  traffic_light_monitor dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .lights_in  (lights_in),
    .locked     (locked),
    .phase      (phase),
    .dwell      (dwell),
    .cycle_done (cycle_done),
    .cycle_cnt  (cycle_cnt),
    .err_code   (err_code),
    .err_seq    (err_seq),
    .err_dwell  (err_dwell),
    .err_any    (err_any)
`ifdef MON_ERR_CAPTURE_EN
    ,
    .cap_valid  (cap_valid),
    .cap_code   (cap_code),
    .cap_phase  (cap_phase),
    .cap_dwell  (cap_dwell)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a code for one clock edge, then sample just after the edge.
  task automatic drive(input logic [5:0] c);
    lights_in = c;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_locked"}, 32'(locked), 32'(0));
    check({tag, "_phase"}, 32'(phase), 32'(7));
    check({tag, "_dwell"}, 32'(dwell), 32'(0));
    check({tag, "_cycle_cnt"}, 32'(cycle_cnt), 32'(0));
    check({tag, "_pulses"}, 32'({cycle_done, err_code, err_seq, err_dwell}), 32'(0));
    check({tag, "_err_any"}, 32'(err_any), 32'(0));
`ifdef MON_ERR_CAPTURE_EN
    check({tag, "_cap_valid"}, 32'(cap_valid), 32'(0));
`endif
  endtask

  logic [5:0] seg_code [6];
  int         seg_len  [6];
  int         done_cnt;

  initial begin
    seg_code = '{LT_P0, LT_P1, LT_RED, LT_P3, LT_P4, LT_RED};
    seg_len  = '{6, 2, 2, 6, 2, 2};
    clr_n     = 1'b0;
    lights_in = LT_P0;
    #12;
    check_reset_values("reset");
    clr_n = 1'b1;

    // Scenario 1: start off P0, then three clean cycles.
    drive(LT_P1);
    drive(LT_P1);
    check("s1_prelock_locked", 32'(locked), 32'(0));
    check("s1_prelock_phase", 32'(phase), 32'(7));
    done_cnt = 0;
    for (int rep = 0; rep < 3; rep++) begin
      for (int seg = 0; seg < 6; seg++) begin
        for (int k = 0; k < seg_len[seg]; k++) begin
          drive(seg_code[seg]);
          if (cycle_done === 1'b1) done_cnt++;
          check("s1_locked", 32'(locked), 32'(1));
          check("s1_phase", 32'(phase), 32'(seg));
          check("s1_dwell", 32'(dwell), 32'(k + 1));
          check("s1_cycle_done", 32'(cycle_done), 32'(rep > 0 && seg == 0 && k == 0));
          check("s1_err_pulses", 32'({err_code, err_seq, err_dwell}), 32'(0));
        end
      end
    end
    check("s1_done_count", 32'(done_cnt), 32'(2));
    check("s1_cycle_cnt", 32'(cycle_cnt), 32'(2));
    check("s1_err_any", 32'(err_any), 32'(0));

    // Scenario 2: P0 held only 5 cycles.
    for (int k = 1; k <= 5; k++) begin
      drive(LT_P0);
      if (k == 1) begin
        check("s2_cycle_done", 32'(cycle_done), 32'(1));
        check("s2_cycle_cnt", 32'(cycle_cnt), 32'(3));
      end
    end
    check("s2_dwell5", 32'(dwell), 32'(5));
    check("s2_no_early_err", 32'(err_dwell), 32'(0));
    drive(LT_P1);
    check("s2_err_dwell", 32'(err_dwell), 32'(1));
    check("s2_err_seq", 32'(err_seq), 32'(0));
    check("s2_phase", 32'(phase), 32'(1));
    check("s2_locked", 32'(locked), 32'(1));
    check("s2_err_any", 32'(err_any), 32'(1));
    drive(LT_P1);
    check("s2_err_dwell_clear", 32'(err_dwell), 32'(0));
    drive(LT_RED);
    drive(LT_RED);
    check("s2_phase_p2", 32'(phase), 32'(2));

    // Scenario 3: P3 held 9 cycles; single over-long pulse at dwell 6->7.
    for (int k = 1; k <= 9; k++) begin
      drive(LT_P3);
      check("s3_dwell", 32'(dwell), 32'(k));
      check("s3_err_dwell", 32'(err_dwell), 32'(k == 7));
    end
    drive(LT_P4);
    check("s3_p4_err_dwell", 32'(err_dwell), 32'(0));
    check("s3_p4_phase", 32'(phase), 32'(4));
    check("s3_p4_err_seq", 32'(err_seq), 32'(0));
    drive(LT_P4);
    drive(LT_RED);
    check("s3_phase_p5", 32'(phase), 32'(5));
    drive(LT_RED);
    drive(LT_P0);
    check("s3_cycle_done", 32'(cycle_done), 32'(1));
    check("s3_cycle_cnt", 32'(cycle_cnt), 32'(4));
    for (int k = 0; k < 5; k++) drive(LT_P0);
    drive(LT_P1);
    drive(LT_P1);

    // Wrong successor into P0 re-locks on the same edge.
    drive(LT_P0);
    check("relock_err_seq", 32'(err_seq), 32'(1));
    check("relock_locked", 32'(locked), 32'(1));
    check("relock_phase", 32'(phase), 32'(0));
    check("relock_dwell", 32'(dwell), 32'(1));
    check("relock_err_dwell", 32'(err_dwell), 32'(0));
    check("relock_cycle_done", 32'(cycle_done), 32'(0));

    // Reset mid-run wipes the cycle history.
    clr_n = 1'b0;
    #2;
    check_reset_values("reset2");
    clr_n = 1'b1;

    // Scenario 4: locked in P0 for 6, then all-red skipping yellow.
    drive(LT_P1);
    for (int k = 0; k < 6; k++) drive(LT_P0);
    check("s4_locked_pre", 32'(locked), 32'(1));
    check("s4_dwell_pre", 32'(dwell), 32'(6));
    drive(LT_RED);
    check("s4_err_seq", 32'(err_seq), 32'(1));
    check("s4_err_dwell", 32'(err_dwell), 32'(0));
    check("s4_locked", 32'(locked), 32'(0));
    check("s4_phase", 32'(phase), 32'(7));
    check("s4_err_any", 32'(err_any), 32'(1));
`ifdef MON_ERR_CAPTURE_EN
    check("s4_cap_valid", 32'(cap_valid), 32'(1));
    check("s4_cap_code", 32'(cap_code), 32'(6'b100100));
    check("s4_cap_phase", 32'(cap_phase), 32'(0));
    check("s4_cap_dwell", 32'(cap_dwell), 32'(6));
`endif
    drive(LT_RED);
    check("s4_err_seq_clear", 32'(err_seq), 32'(0));
    check("s4_still_unlocked", 32'(locked), 32'(0));
    drive(LT_P0);
    check("s4_relock", 32'(locked), 32'(1));
    check("s4_relock_phase", 32'(phase), 32'(0));
    check("s4_relock_dwell", 32'(dwell), 32'(1));

    // Scenario 5: illegal code right after lock (dwell check must be suppressed).
    drive(6'b111111);
    check("s5_err_code", 32'(err_code), 32'(1));
    check("s5_err_dwell", 32'(err_dwell), 32'(0));
    check("s5_err_seq", 32'(err_seq), 32'(0));
    check("s5_locked", 32'(locked), 32'(0));
    check("s5_phase", 32'(phase), 32'(7));
    check("s5_err_any", 32'(err_any), 32'(1));
`ifdef MON_ERR_CAPTURE_EN
    check("s5_cap_code", 32'(cap_code), 32'(6'b100100));
    check("s5_cap_phase", 32'(cap_phase), 32'(0));
    check("s5_cap_dwell", 32'(cap_dwell), 32'(6));
`endif
    drive(LT_P0);
    check("s5_err_code_clear", 32'(err_code), 32'(0));
    check("s5_err_any_sticky", 32'(err_any), 32'(1));
    check("s5_relock", 32'(locked), 32'(1));
    #3;
    clr_n = 1'b0;
    #1;
    check_reset_values("s5_async_reset");
    lights_in = LT_P1;
    @(posedge clk);
    #1;
    check_reset_values("s5_held_reset");
    clr_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
